// File: rtl/core_out_drain.sv
// Output drain stage: latches one full accumulator tile from the core and
// streams it out N_LANE elements per beat over a valid/ready interface.

// Per-lane beat mux. Selects element (beat*N_LANE + LANE) out of the tile buffer.
module core_out_drain_lane #(
  parameter int DW_ADD = 32,
  parameter int N_LANE = 16,
  parameter int N_ELEM = 256,
  parameter int BW     = 4,
  parameter int LANE   = 0
) (
  input  logic [DW_ADD*N_ELEM-1:0] i_buf,
  input  logic [BW-1:0]            i_beat,
  output logic [DW_ADD-1:0]        o_elem
);
  int w_idx;

  always_comb begin
    w_idx  = int'(i_beat) * N_LANE + LANE;
    o_elem = '0;
    // A beat index past the tile end can only appear when NUM_BEATS is not a
    // power of two. That index is unreachable, but the mux stays in range anyway.
    if (w_idx < N_ELEM) o_elem = i_buf[w_idx*DW_ADD +: DW_ADD];
  end
endmodule

module core_out_drain #(
  parameter  int N_GROUP   = 16,
  parameter  int N_UNIT    = 16,
  parameter  int DW_ADD    = 32,
  parameter  int N_LANE    = 16,
  localparam int N_ELEM    = N_GROUP * N_UNIT,
  localparam int DW_IN     = DW_ADD * N_ELEM,
  localparam int NUM_BEATS = N_ELEM / N_LANE,
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW_IN-1:0]         in_out,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW_ADD*N_LANE-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [BW-1:0]            out_beat,
  output logic                     overflow,
  input  logic                     clr_overflow
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);

  logic [0:0]       r_state;
  logic [DW_IN-1:0] r_buf;
  logic [BW-1:0]    r_beat;
  logic             r_ovf;

  logic w_valid, w_last, w_hs, w_ready, w_cap;

  assign w_valid = (r_state == S_DRAIN);
  assign w_last  = w_valid && (r_beat == LAST_BEAT);
  assign w_hs    = w_valid && out_ready;
  // Accepting on the final handshake lets back-to-back tiles drain without a bubble.
  assign w_ready = (r_state == S_IDLE) || (w_hs && w_last);
  assign w_cap   = in_valid && w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_beat  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_buf   <= in_out;
        r_beat  <= '0;
        r_state <= S_DRAIN;
      end else if (w_hs) begin
        if (w_last) begin
          r_beat  <= '0;
          r_state <= S_IDLE;
        end else begin
          r_beat  <= r_beat + BW'(1);
        end
      end
      // A dropped tile sets the flag even when a clear arrives in the same cycle.
      if (in_valid && !w_ready) r_ovf <= 1'b1;
      else if (clr_overflow)    r_ovf <= 1'b0;
    end
  end

  genvar l;
  generate
    for (l = 0; l < N_LANE; l++) begin : g_lane
      core_out_drain_lane #(
        .DW_ADD(DW_ADD), .N_LANE(N_LANE), .N_ELEM(N_ELEM), .BW(BW), .LANE(l)
      ) u_lane (
        .i_buf  (r_buf),
        .i_beat (r_beat),
        .o_elem (out_data[l*DW_ADD +: DW_ADD])
      );
    end
  endgenerate

  assign in_ready  = w_ready;
  assign out_valid = w_valid;
  assign out_last  = w_last;
  assign out_beat  = r_beat;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_core_out_drain.sv
// Bench for core_out_drain: beat-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_core_out_drain;
  localparam int DW_IN = 8192;
  localparam int DW_OD = 512;
  localparam int NB    = 16;

  typedef struct packed {
    logic [DW_OD-1:0] data;
    logic [3:0]       beat;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [DW_IN-1:0]  in_out;
  logic              in_valid, in_ready, out_valid, out_ready, out_last, overflow, clr;
  logic [DW_OD-1:0]  out_data;
  logic [3:0]        out_beat;

  logic              in_valid2, in_ready2, out_valid2, out_ready2, out_last2, overflow2;
  logic [DW_IN-1:0]  out_data2;
  logic [0:0]        out_beat2;

  int tests = 0, errs = 0, hs = 0;
  beat_t q[$];
  logic  mov = 1'b0;

  always #5 clk = ~clk;

  core_out_drain dut (
    .clk(clk), .reset(reset), .in_out(in_out), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_beat(out_beat), .overflow(overflow), .clr_overflow(clr)
  );

  core_out_drain #(.N_LANE(256)) dut2 (
    .clk(clk), .reset(reset), .in_out(in_out), .in_valid(in_valid2), .in_ready(in_ready2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2), .out_last(out_last2),
    .out_beat(out_beat2), .overflow(overflow2), .clr_overflow(clr)
  );

  task automatic chk(input string name, input logic [DW_OD-1:0] act, input logic [DW_OD-1:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW_IN-1:0] tile(input int off);
    logic [DW_IN-1:0] t;
    for (int j = 0; j < 256; j++) t[j*32 +: 32] = 32'(j + off);
    return t;
  endfunction

  function automatic logic [31:0] lane(input logic [DW_OD-1:0] d, input int k);
    return d[k*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference model: the pending stream is a queue of beats; a tile is accepted
  // when nothing is pending or only its final beat is leaving this cycle.
  always @(negedge clk) begin
    logic exp_rdy;
    if (!reset) begin
      q.delete();
      mov = 1'b0;
      chk("m_rst_valid", out_valid, 0);
      chk("m_rst_ovf", overflow, 0);
      chk("m_rst_beat", out_beat, 0);
    end else begin
      chk("m_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("m_data", out_data, q[0].data);
        chk("m_beat", out_beat, q[0].beat);
        chk("m_last", out_last, q[0].last);
      end else begin
        chk("m_last_idle", out_last, 0);
      end
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_ovf", overflow, mov);
      if (q.size() > 0 && out_ready) begin
        void'(q.pop_front());
        hs++;
      end
      if (in_valid && exp_rdy)
        for (int b = 0; b < NB; b++)
          q.push_back('{data: in_out[b*DW_OD +: DW_OD], beat: 4'(b), last: (b == NB-1)});
      if (in_valid && !exp_rdy) mov = 1'b1;
      else if (clr)             mov = 1'b0;
    end
  end

  task automatic capture(input int off);
    in_out = tile(off); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain_all(input string name);
    for (int i = 0; i < 60 && out_valid; i++) step();
    chk(name, out_valid, 0);
  endtask

  initial begin
    int h0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0; in_out = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ready", in_ready, 1);
    reset = 1'b1;
    step();

    // 1: single tile, no backpressure
    out_ready = 1'b1;
    capture(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_b0_l0", lane(out_data, 0), 1);
    chk("t1_b0_l15", lane(out_data, 15), 16);
    chk("t1_b0_last", out_last, 0);
    repeat (15) step();
    chk("t1_beat15", out_beat, 15);
    chk("t1_b15_l15", lane(out_data, 15), 256);
    chk("t1_b15_last", out_last, 1);
    step();
    chk("t1_idle_valid", out_valid, 0);
    chk("t1_idle_ready", in_ready, 1);

    // 2: backpressure at beat 3
    h0 = hs;
    capture(1);
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_beat", out_beat, 3);
      chk("t2_hold_l0", lane(out_data, 0), 49);
      chk("t2_hold_l15", lane(out_data, 15), 64);
      step();
    end
    out_ready = 1'b1;
    drain_all("t2_drain");
    chk("t2_hs_count", 32'(hs - h0), 16);

    // 3: back-to-back tile on the final handshake
    capture(1);
    repeat (15) step();
    chk("t3_at_last", out_last, 1);
    chk("t3_ready_last", in_ready, 1);
    capture(1000);
    chk("t3_b_valid", out_valid, 1);
    chk("t3_b_beat", out_beat, 0);
    chk("t3_b_l0", lane(out_data, 0), 1000);
    drain_all("t3_drain");

    // 4: overflow while draining
    capture(1);
    repeat (5) step();
    chk("t4_beat5", out_beat, 5);
    capture(5000);
    chk("t4_ovf_set", overflow, 1);
    repeat (9) step();
    chk("t4_b15_l15", lane(out_data, 15), 256);
    step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    capture(1);
    in_valid = 1'b1; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    chk("t4_set_wins", overflow, 1);
    drain_all("t4_drain");
    clr = 1'b1; step(); clr = 1'b0;

    // 5: async reset mid-drain
    capture(1);
    repeat (2) step();
    capture(7000);
    repeat (4) step();
    chk("t5_beat7", out_beat, 7);
    chk("t5_ovf_pre", overflow, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_ovf", overflow, 0);
    step();
    reset = 1'b1;
    chk("t5_rel_ready", in_ready, 1);
    capture(1);
    chk("t5_new_beat", out_beat, 0);
    chk("t5_new_l0", lane(out_data, 0), 1);
    drain_all("t5_drain");

    // 6: single-beat configuration
    in_out = tile(1); in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    chk("t6_valid", out_valid2, 1);
    chk("t6_last", out_last2, 1);
    chk("t6_beat", out_beat2, 0);
    chk("t6_l0", out_data2[31:0], 1);
    chk("t6_l255", out_data2[255*32 +: 32], 256);
    out_ready2 = 1'b1;
    step();
    chk("t6_done", out_valid2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
